// File: rtl/load_writeback.sv
// Load/writeback stage: formats load data, sequences register-file writes and flags bad loads.
// Defining LOAD_WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs that mirror the write port.
module load_writeback #(
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_reg_write,
   input  logic                     in_is_load,
   input  logic [ADDRESS_WIDTH-1:0] in_rd,
   input  logic [2:0]               in_funct3,
   input  logic [31:0]              in_alu_result,
   input  logic                     mem_rvalid,
   input  logic [31:0]              mem_rdata,
   output logic                     wb_we,
   output logic [ADDRESS_WIDTH-1:0] wb_rd,
   output logic [31:0]              wb_wd,
   output logic                     load_err
`ifdef LOAD_WB_FWD_EN
   ,
   output logic                     fwd_valid,
   output logic [ADDRESS_WIDTH-1:0] fwd_rd,
   output logic [31:0]              fwd_data
`endif
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOAD = 2'd1,
      WRITE     = 2'd2
   } state_t;

   state_t                   state_reg;
   logic [ADDRESS_WIDTH-1:0] pend_rd_reg;
   logic [2:0]               pend_funct3_reg;
   logic [1:0]               pend_addr_reg;
   logic                     pend_reg_write_reg;

   logic                     accept;
   logic                     load_bad;
   logic [31:0]              shifted_word;
   logic [7:0]               byte_val;
   logic [15:0]              half_val;
   logic [31:0]              load_data;

   assign in_ready = (state_reg != WAIT_LOAD);
   assign accept   = in_valid && in_ready;

   // Unknown funct3 encodings and misaligned halfword/word addresses are rejected.
   always_comb begin
      load_bad = 1'b1;
      case (in_funct3)
         3'b000, 3'b100: load_bad = 1'b0;
         3'b001, 3'b101: load_bad = in_alu_result[0];
         3'b010:         load_bad = (in_alu_result[1:0] != 2'b00);
         default:        load_bad = 1'b1;
      endcase
   end

   assign shifted_word = mem_rdata >> {pend_addr_reg, 3'b000};
   assign byte_val     = shifted_word[7:0];
   assign half_val     = pend_addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      load_data = mem_rdata;
      case (pend_funct3_reg)
         3'b000:  load_data = {{24{byte_val[7]}}, byte_val};
         3'b001:  load_data = {{16{half_val[15]}}, half_val};
         3'b100:  load_data = {24'd0, byte_val};
         3'b101:  load_data = {16'd0, half_val};
         default: load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg          <= IDLE;
         wb_we              <= 1'b0;
         wb_rd              <= '0;
         wb_wd              <= 32'd0;
         load_err           <= 1'b0;
         pend_rd_reg        <= '0;
         pend_funct3_reg    <= 3'd0;
         pend_addr_reg      <= 2'd0;
         pend_reg_write_reg <= 1'b0;
      end else begin
         wb_we    <= 1'b0;
         load_err <= 1'b0;
         case (state_reg)
            WAIT_LOAD: begin
               if (mem_rvalid) begin
                  wb_rd     <= pend_rd_reg;
                  wb_wd     <= load_data;
                  wb_we     <= pend_reg_write_reg && (pend_rd_reg != '0);
                  state_reg <= WRITE;
               end
            end
            default: begin
               // IDLE and WRITE both accept a new instruction, giving back-to-back writes.
               if (accept) begin
                  if (!in_is_load) begin
                     wb_rd     <= in_rd;
                     wb_wd     <= in_alu_result;
                     wb_we     <= in_reg_write && (in_rd != '0);
                     state_reg <= WRITE;
                  end else if (load_bad) begin
                     load_err  <= 1'b1;
                     state_reg <= IDLE;
                  end else begin
                     pend_rd_reg        <= in_rd;
                     pend_funct3_reg    <= in_funct3;
                     pend_addr_reg      <= in_alu_result[1:0];
                     pend_reg_write_reg <= in_reg_write;
                     state_reg          <= WAIT_LOAD;
                  end
               end else begin
                  state_reg <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef LOAD_WB_FWD_EN
   assign fwd_valid = wb_we;
   assign fwd_rd    = wb_rd;
   assign fwd_data  = wb_wd;
`endif

endmodule

// File: doc/load_writeback.md
LOAD_WRITEBACK -- requirements
Module: load_writeback

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 5, register-index width; SHALL size in_rd and wb_rd.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream memory-stage result valid.
REQ-005 in_ready  output  1  block can accept; transfer when in_valid && in_ready at clk rise.
REQ-006 in_reg_write  input  1  instruction writes a destination register.
REQ-007 in_is_load  input  1  1 = load (data from memory), 0 = ALU result.
REQ-008 in_rd  input  ADDRESS_WIDTH  destination register index.
REQ-009 in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 in_alu_result  input  32  ALU result, or byte address for loads.
REQ-011 mem_rvalid  input  1  data-memory read data valid.
REQ-012 mem_rdata  input  32  aligned 32-bit word read from data memory.
REQ-013 wb_we  output  1  register-file write enable (drives WE3).
REQ-014 wb_rd  output  ADDRESS_WIDTH  write index (drives AD3).
REQ-015 wb_wd  output  32  write data (drives WD3).
REQ-016 load_err  output  1  one-cycle pulse on misaligned or illegal load.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_LOAD, WRITE.
REQ-018 in_ready SHALL be 1 in IDLE and WRITE, 0 in WAIT_LOAD.
REQ-019 IDLE/WRITE + accepted non-load: capture in_rd, in_alu_result -> WRITE; write visible next cycle (latency 1).
REQ-020 IDLE/WRITE + accepted legal aligned load: capture rd, funct3, addr[1:0] -> WAIT_LOAD.
REQ-021 WAIT_LOAD: hold until mem_rvalid; on mem_rvalid latch extracted data -> WRITE (write one cycle after mem_rvalid).
REQ-022 WRITE with no accepted transfer -> IDLE; WRITE with transfer follows REQ-019/020 (back-to-back, no bubble).
REQ-023 wb_we SHALL be 1 exactly for one cycle in WRITE, and only if captured reg_write=1 and rd != 0.
REQ-024 wb_rd/wb_wd SHALL hold captured values throughout WRITE; outside WRITE hold last values.
REQ-025 Byte select: byte = mem_rdata[8*addr[1:0]+7 : 8*addr[1:0]]; halfword = mem_rdata[16*addr[1]+15 : 16*addr[1]].
REQ-026 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes word unchanged.
REQ-027 Misaligned (LH/LHU addr[0]=1, LW addr[1:0]!=0) or illegal funct3 (011,110,111): accept, pulse load_err next cycle, no write, go IDLE, do not wait for memory.
REQ-028 mem_rvalid outside WAIT_LOAD SHALL be ignored.
REQ-029 in_reg_write=0 instructions SHALL still traverse states (loads still wait for data) but never assert wb_we.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, wb_we=0, wb_rd=0, wb_wd=0, load_err=0, in_ready=1.
REQ-031 Reset during WAIT_LOAD or WRITE SHALL drop the pending operation; no write after release.
REQ-032 First transfer accepted on first rising edge with rst_n high.

Configuration
REQ-033 Macro LOAD_WB_FWD_EN defined: add outputs fwd_valid (1), fwd_rd (ADDRESS_WIDTH), fwd_data (32) equal to wb_we, wb_rd, wb_wd, for execute-stage bypass.
REQ-034 LOAD_WB_FWD_EN undefined: those ports SHALL not exist; all other behaviour identical.

Verification
REQ-035 ALU op rd=5, result 0x1234_5678 accepted cycle N -> wb_we=1, wb_rd=5, wb_wd=0x12345678 at cycle N+1 only.
REQ-036 LB addr 0x...03, mem_rdata 0x80FF_FF00 after 3 wait cycles -> in_ready=0 while waiting; write 0xFFFF_FF80 one cycle after mem_rvalid.
REQ-037 LHU addr 0x...02, mem_rdata 0xBEEF_0000 -> wb_wd=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-038 LW addr 0x...01 -> load_err pulse one cycle, wb_we stays 0, state IDLE, stray mem_rvalid ignored.
REQ-039 ALU op rd=0 -> wb_we=0; back-to-back ALU ops rd=1,2 in consecutive cycles -> two consecutive writes.
REQ-040 rst_n low in WAIT_LOAD, mem_rvalid after release -> no write, in_ready=1.
